// File: rtl/d_mem_responder_pkg.sv
// d_mem_responder_pkg: shared state encoding, word size and address checking for the data-memory responder.
package d_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int WORD_BYTES = 4;

   // A request is rejected when it is not word aligned or falls past the last stored word.
   function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/d_mem_responder_latency_counter.sv
// d_mem_responder_latency_counter: loadable down-counter that flags when the access cycle is reached.
module d_mem_responder_latency_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = cnt_q == '0;

endmodule

// File: rtl/d_mem_responder.sv
// d_mem_responder: slave end of the core's data-memory port; answers each word load/store
// after a fixed LATENCY, flagging misaligned or out-of-range addresses.
module d_mem_responder
   import d_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_error_o,
   output logic        busy_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_e        state_q;
   logic          req_ready_q, resp_valid_q, resp_error_q;
   logic [31:0]   resp_rdata_q;
   logic          write_q, err_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mem_q [DEPTH_WORDS];
   logic          accept, access, cnt_zero;

   assign accept = (state_q == IDLE) && req_valid_i && req_ready_q;
   assign access = (state_q == WAIT) && cnt_zero;

   d_mem_responder_latency_counter #(.W(4)) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept),
      .dec_i      (state_q == WAIT),
      .load_val_i (4'(LATENCY - 1)),
      .zero_o     (cnt_zero)
   );

   // Storage is deliberately outside the reset domain so contents survive a reset.
   always_ff @(posedge clk_i) begin
      if (access && write_q && !err_q) mem_q[idx_q] <= wdata_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  write_q     <= req_write_i;
                  err_q       <= addr_err(req_addr_i, 32'(DEPTH_WORDS));
                  idx_q       <= req_addr_i[AW+1:2];
                  wdata_q     <= req_wdata_i;
                  req_ready_q <= 1'b0;
                  state_q     <= WAIT;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_zero) begin
                  resp_valid_q <= 1'b1;
                  resp_error_q <= err_q;
                  resp_rdata_q <= (write_q || err_q) ? '0 : mem_q[idx_q];
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_error_o = resp_error_q;
   assign busy_o       = state_q != IDLE;

endmodule

// File: tb/tb_d_mem_responder.sv
// tb_d_mem_responder: checks three responder builds (LATENCY 2, 1, 15) against a word-array model.
module tb_d_mem_responder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rv [3], rw [3], rr [3];
   logic [31:0] ra [3], wd [3];
   logic        rq [3], vo [3], eo [3], by [3];
   logic [31:0] rdo [3];

   int lat_of [3] = '{2, 1, 15};

   d_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[0]), .req_ready_o(rq[0]), .req_write_i(rw[0]),
      .req_addr_i(ra[0]), .req_wdata_i(wd[0]), .resp_valid_o(vo[0]), .resp_ready_i(rr[0]),
      .resp_rdata_o(rdo[0]), .resp_error_o(eo[0]), .busy_o(by[0]));
   d_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[1]), .req_ready_o(rq[1]), .req_write_i(rw[1]),
      .req_addr_i(ra[1]), .req_wdata_i(wd[1]), .resp_valid_o(vo[1]), .resp_ready_i(rr[1]),
      .resp_rdata_o(rdo[1]), .resp_error_o(eo[1]), .busy_o(by[1]));
   d_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u2 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[2]), .req_ready_o(rq[2]), .req_write_i(rw[2]),
      .req_addr_i(ra[2]), .req_wdata_i(wd[2]), .resp_valid_o(vo[2]), .resp_ready_i(rr[2]),
      .resp_rdata_o(rdo[2]), .resp_error_o(eo[2]), .busy_o(by[2]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One complete transaction; returns response contents and observed latency in cycles.
   task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output logic [31:0] rd, output logic er, output int lat);
      int n;
      bit ok;
      n = 0;
      while (!rq[k] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 32'(rq[k]), 32'd1);
      rv[k] = 1'b1; rw[k] = wr; ra[k] = a; wd[k] = d; rr[k] = 1'b0;
      @(negedge clk);
      rv[k] = 1'b0; rw[k] = ~wr; ra[k] = 32'hFFFF_FFF3; wd[k] = $urandom;
      lat = 0;
      ok = 1'b1;
      while (!vo[k] && lat < 40) begin
         ok &= by[k] && !rq[k];
         @(negedge clk);
         lat++;
      end
      chk("wait_busy", 32'(ok), 32'd1);
      chk("resp_valid_seen", 32'(vo[k]), 32'd1);
      rd = rdo[k];
      er = eo[k];
      ok = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         ok &= vo[k] && rdo[k] === rd && eo[k] === er && !rq[k] && by[k];
      end
      if (hold > 0) chk("hold_stable", 32'(ok), 32'd1);
      rr[k] = 1'b1;
      @(negedge clk);
      rr[k] = 1'b0;
      chk("consumed_valid", 32'(vo[k]), 32'd0);
      chk("consumed_ready", 32'(rq[k]), 32'd1);
      chk("consumed_busy", 32'(by[k]), 32'd0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      bit          err;
      int          hold;
   } vec_t;

   vec_t        tbl [$];
   logic [31:0] model [256];

   initial begin
      logic [31:0] rd, a, d;
      logic        er;
      int          lat, n, a0, a1;
      bit          wr, xerr;

      tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0});
      tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 5});
      tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1, 0});
      tbl.push_back('{1'b1, 32'h0000_03FC, 32'h55AA_55AA, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b0, 32'h0000_03FC, 32'h0,         32'h55AA_55AA, 1'b0, 2});
      tbl.push_back('{1'b1, 32'h0000_0022, 32'hBAD0_BAD0, 32'h0, 1'b1, 0});
      tbl.push_back('{1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0, 0});
      tbl.push_back('{1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 1'b0, 3});
      tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1, 0});

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rv[k] = 1'b0; rw[k] = 1'b0; rr[k] = 1'b0; ra[k] = '0; wd[k] = '0;
      end

      // Reset release
      repeat (3) begin
         @(negedge clk);
         chk("rst_ready", 32'(rq[0]), 32'd0);
         chk("rst_valid", 32'(vo[0]), 32'd0);
         chk("rst_busy", 32'(by[0]), 32'd0);
      end
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) chk("release_ready_low", 32'(rq[k]), 32'd0);
      chk("release_rdata", rdo[0], 32'h0);
      chk("release_error", 32'(eo[0]), 32'd0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("release_ready_high", 32'(rq[k]), 32'd1);
      chk("release_busy", 32'(by[0]), 32'd0);

      // Directed vectors on the LATENCY=2 build
      foreach (tbl[i]) begin
         txn(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
         chk($sformatf("vec%0d_error", i), 32'(er), 32'(tbl[i].err));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      end

      // Reset while waiting: the store to 0x20 must never land
      n = 0;
      while (!rq[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; wd[0] = 32'hCAFE_F00D;
      @(negedge clk);
      rv[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midwait_ready", 32'(rq[0]), 32'd0);
      chk("midwait_valid", 32'(vo[0]), 32'd0);
      chk("midwait_busy", 32'(by[0]), 32'd0);
      chk("midwait_rdata", rdo[0], 32'h0);
      chk("midwait_error", 32'(eo[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(0, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
      chk("midwait_readback", rd, 32'h1111_1111);
      chk("midwait_readback_err", 32'(er), 32'd0);

      // Randomised traffic against the word-array model
      for (int w = 0; w < 16; w++) begin
         d = $urandom;
         txn(0, 1'b1, 32'(w * 4), d, 0, rd, er, lat);
         model[w] = d;
         chk("init_err", 32'(er), 32'd0);
      end
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         d  = $urandom;
         n  = $urandom_range(0, 9);
         a  = (n == 0) ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)) :
              (n == 1) ? 32'(1024 + $urandom_range(0, 4000) * 4) :
                         32'($urandom_range(0, 15) * 4);
         xerr = (a % 4 != 0) || (a >= 32'd1024);
         txn(0, wr, a, d, $urandom_range(0, 3), rd, er, lat);
         chk($sformatf("rand%0d_error", i), 32'(er), 32'(xerr));
         chk($sformatf("rand%0d_rdata", i), rd, (wr || xerr) ? 32'h0 : model[a / 4]);
         chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd2);
         if (wr && !xerr) model[a / 4] = d;
      end

      // Back-to-back stores with resp_ready tied high on the LATENCY=1 and LATENCY=15 builds
      for (int k = 1; k < 3; k++) begin
         rr[k] = 1'b1;
         n = 0;
         while (!rq[k] && n < 40) begin
            @(negedge clk);
            n++;
         end
         rv[k] = 1'b1; rw[k] = 1'b1; ra[k] = 32'h0; wd[k] = 32'hA5A5_0000 + 32'(k);
         @(negedge clk);
         a0 = cyc;
         ra[k] = 32'h4; wd[k] = 32'h5A5A_0000 + 32'(k);
         n = 0;
         while (!rq[k] && n < 40) begin
            @(negedge clk);
            n++;
         end
         a1 = cyc + 1;
         @(negedge clk);
         rv[k] = 1'b0;
         chk($sformatf("spacing_L%0d", lat_of[k]), 32'(a1 - a0), 32'(lat_of[k] + 2));
         n = 0;
         while (!vo[k] && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("pulse_start_L%0d", lat_of[k]), 32'(vo[k]), 32'd1);
         @(negedge clk);
         chk($sformatf("pulse_end_L%0d", lat_of[k]), 32'(vo[k]), 32'd0);
         rr[k] = 1'b0;
         txn(k, 1'b0, 32'h0, 32'h0, 0, rd, er, lat);
         chk($sformatf("readback0_L%0d", lat_of[k]), rd, 32'hA5A5_0000 + 32'(k));
         chk($sformatf("latency_L%0d", lat_of[k]), 32'(lat), 32'(lat_of[k]));
         txn(k, 1'b0, 32'h4, 32'h0, 1, rd, er, lat);
         chk($sformatf("readback4_L%0d", lat_of[k]), rd, 32'h5A5A_0000 + 32'(k));
         chk($sformatf("readback4_err_L%0d", lat_of[k]), 32'(er), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
